// File: rtl/minirisc_bus_arbiter_pkg.sv
// Shared definitions for the MiniRISC data-memory bus arbiter.
// Holds the arbiter state encoding and the round-robin search helper.
package minirisc_bus_pkg;

    localparam int OWNER_W     = 3;
    localparam int MAX_MASTERS = 1 << OWNER_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWNED  = 2'd1,
        REVOKE = 2'd2
    } arb_state_e;

    // First set bit of req at or after start, wrapping modulo num.
    // Returns start when req is empty; callers gate on |req.
    function automatic logic [OWNER_W-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [OWNER_W-1:0]     start,
        input int                     num
    );
        logic [OWNER_W-1:0] pick;
        logic [OWNER_W-1:0] idx;
        logic               found;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < MAX_MASTERS; k++) begin
            idx = OWNER_W'((int'(start) + k) % num);
            if (!found && (k < num) && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/minirisc_bus_arbiter_if.sv
// Master-side and slave-side signal bundle of the shared data-memory bus.
// The arbiter modport sits between N masters and the single slave bus.
interface minirisc_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8
);
    logic [NUM_MASTERS-1:0]        m_bus_req;
    logic [NUM_MASTERS-1:0]        m_bus_grant;
    logic [NUM_MASTERS*ADDR_W-1:0] m_mst2slv_addr;
    logic [NUM_MASTERS-1:0]        m_mst2slv_wr;
    logic [NUM_MASTERS-1:0]        m_mst2slv_rd;
    logic [NUM_MASTERS*DATA_W-1:0] m_mst2slv_data;
    logic [DATA_W-1:0]             m_slv2mst_data;

    logic [ADDR_W-1:0]             s_mst2slv_addr;
    logic                          s_mst2slv_wr;
    logic                          s_mst2slv_rd;
    logic [DATA_W-1:0]             s_mst2slv_data;
    logic [DATA_W-1:0]             s_slv2mst_data;

    modport arbiter (
        input  m_bus_req, m_mst2slv_addr, m_mst2slv_wr, m_mst2slv_rd,
               m_mst2slv_data, s_slv2mst_data,
        output m_bus_grant, m_slv2mst_data, s_mst2slv_addr, s_mst2slv_wr,
               s_mst2slv_rd, s_mst2slv_data
    );

    modport master (
        output m_bus_req, m_mst2slv_addr, m_mst2slv_wr, m_mst2slv_rd,
               m_mst2slv_data,
        input  m_bus_grant, m_slv2mst_data
    );

    modport slave (
        input  s_mst2slv_addr, s_mst2slv_wr, s_mst2slv_rd, s_mst2slv_data,
        output s_slv2mst_data
    );

endinterface

// File: rtl/minirisc_bus_arbiter_mux.sv
// AND-OR multiplexer selecting the granted master onto the slave bus.
// Purely combinational; an all-zero grant yields an all-zero slave bus.
module minirisc_bus_mux #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8
) (
    input  logic [NUM_MASTERS-1:0]        grant,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]        m_wr,
    input  logic [NUM_MASTERS-1:0]        m_rd,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0]             s_addr,
    output logic                          s_wr,
    output logic                          s_rd,
    output logic [DATA_W-1:0]             s_data
);

    always_comb begin
        s_addr = '0;
        s_wr   = 1'b0;
        s_rd   = 1'b0;
        s_data = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            s_addr |= m_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{grant[i]}};
            s_data |= m_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}};
            s_wr   |= m_wr[i] & grant[i];
            s_rd   |= m_rd[i] & grant[i];
        end
    end

endmodule

// File: rtl/minirisc_bus_arbiter.sv
// Round-robin N-master arbiter for the MiniRISC data-memory bus with
// registered one-hot grant, optional parking and optional hold timeout.
//
//   state  | meaning
//   IDLE   | no grant; next requester from rr_ptr wins
//   OWNED  | one grant bit set (active or parked owner)
//   REVOKE | one-cycle gap after a timeout; revoked master is skipped
module minirisc_bus_arbiter
    import minirisc_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int MAX_HOLD    = 0,
    parameter int PARK        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    minirisc_bus_arbiter_if.arbiter bus,
    output logic [OWNER_W-1:0]    owner_id,
    output logic                  bus_busy,
    output logic                  timeout_evt
);

    localparam int HOLD_W = 16;

    if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_num_masters
        $error("minirisc_bus_arbiter: NUM_MASTERS must be 2..8");
    end

    arb_state_e             state_q, state_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [OWNER_W-1:0]     rr_q, rr_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;

    logic [MAX_MASTERS-1:0] req_ext;
    logic [MAX_MASTERS-1:0] others;
    logic                   owner_req;
    logic [OWNER_W-1:0]     after_owner;
    logic [OWNER_W-1:0]     pick_idle;
    logic [OWNER_W-1:0]     pick_next;
    logic                   take;
    logic [OWNER_W-1:0]     pick;

    assign req_ext     = MAX_MASTERS'(bus.m_bus_req);
    assign owner_req   = req_ext[owner_q];
    assign others      = req_ext & ~(MAX_MASTERS'(1) << owner_q);
    assign after_owner = OWNER_W'((int'(owner_q) + 1) % NUM_MASTERS);
    assign pick_idle   = rr_pick(req_ext, rr_q, NUM_MASTERS);
    // Search from the slot after the owner; the owner itself is never a candidate.
    assign pick_next   = rr_pick(others, after_owner, NUM_MASTERS);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        take    = 1'b0;
        pick    = pick_next;

        case (state_q)
            IDLE: begin
                if (|req_ext) begin
                    take = 1'b1;
                    pick = pick_idle;
                end
            end
            OWNED: begin
                if (owner_req) begin
                    if (|others) begin
                        if ((MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD - 1))) begin
                            state_d = REVOKE;
                            grant_d = '0;
                            hold_d  = '0;
                        end else if (hold_q != '1) begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end else if (|others) begin
                    take = 1'b1;
                end else if (PARK == 0) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            REVOKE: begin
                if (|others) begin
                    take = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        if (take) begin
            state_d = OWNED;
            owner_d = pick;
            grant_d = NUM_MASTERS'(1) << pick;
            hold_d  = '0;
            rr_d    = OWNER_W'((int'(pick) + 1) % NUM_MASTERS);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.m_bus_grant    = grant_q;
    assign bus.m_slv2mst_data = bus.s_slv2mst_data;
    assign owner_id           = owner_q;
    assign bus_busy           = |grant_q;
    assign timeout_evt        = (state_q == REVOKE);

    minirisc_bus_mux #(
        .NUM_MASTERS (NUM_MASTERS),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W)
    ) u_mux (
        .grant  (grant_q),
        .m_addr (bus.m_mst2slv_addr),
        .m_wr   (bus.m_mst2slv_wr),
        .m_rd   (bus.m_mst2slv_rd),
        .m_data (bus.m_mst2slv_data),
        .s_addr (bus.s_mst2slv_addr),
        .s_wr   (bus.s_mst2slv_wr),
        .s_rd   (bus.s_mst2slv_rd),
        .s_data (bus.s_mst2slv_data)
    );

endmodule
